// File: rtl/wind_decoder_if.sv
// Bundles the sample inputs and decoded outputs of the wind-light decoder.
interface wind_decoder_if;
  logic       en;
  logic [2:0] lights;
  logic [1:0] w;
  logic       valid;
  logic       err;
  logic [7:0] switch_cnt;

  modport master (
    output en,
    output lights,
    input  w,
    input  valid,
    input  err,
    input  switch_cnt
  );

  modport slave (
    input  en,
    input  lights,
    output w,
    output valid,
    output err,
    output switch_cnt
  );
endinterface

// File: rtl/wind_decoder.sv
// Decodes a rotating three-light pattern into a wind direction, requiring
// LOCK_COUNT consecutive same-class transitions before the mode is reported.
module wind_decoder #(
  parameter int LOCK_COUNT = 3
) (
  input logic          clk,
  input logic          reset,
  wind_decoder_if.slave bus
);

  localparam logic [3:0] LOCK_C    = 4'(LOCK_COUNT);
  localparam logic [1:0] CLS_CALM  = 2'b00;
  localparam logic [1:0] CLS_LEFT  = 2'b01;
  localparam logic [1:0] CLS_RIGHT = 2'b10;
  localparam logic [1:0] CLS_ILL   = 2'b11;

  function automatic logic is_legal(input logic [2:0] code);
    case (code)
      3'b010, 3'b101, 3'b100, 3'b001: is_legal = 1'b1;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] classify(input logic [2:0] p, input logic [2:0] c);
    case ({p, c})
      6'b010_101, 6'b101_010:             classify = CLS_CALM;
      6'b010_100, 6'b100_001, 6'b001_010: classify = CLS_LEFT;
      6'b010_001, 6'b001_100, 6'b100_010: classify = CLS_RIGHT;
      default:                            classify = CLS_ILL;
    endcase
  endfunction

  logic [2:0] prev_r, prev_s;
  logic       prev_ok_r, prev_ok_s;
  logic [1:0] cand_r, cand_s;
  logic [3:0] cnt_r, cnt_s;
  logic [1:0] w_r, w_s;
  logic       valid_r, valid_s;
  logic       err_r, err_s;
  logic [7:0] sw_r, sw_s;
  logic       locked_once_r, locked_once_s;

  logic [1:0] cls_s;
  logic [3:0] cnt_inc_s;
  logic       lock_s;
  logic [1:0] lock_mode_s;

  // Next-state: classify the sample against prev, track the candidate run, detect lock events.
  always_comb begin
    prev_s        = prev_r;
    prev_ok_s     = prev_ok_r;
    cand_s        = cand_r;
    cnt_s         = cnt_r;
    w_s           = w_r;
    valid_s       = valid_r;
    err_s         = 1'b0;
    sw_s          = sw_r;
    locked_once_s = locked_once_r;
    lock_s        = 1'b0;
    lock_mode_s   = cand_r;
    cls_s         = classify(prev_r, bus.lights);
    cnt_inc_s     = (cnt_r >= LOCK_C) ? LOCK_C : cnt_r + 4'd1;

    if (bus.en) begin
      if (!is_legal(bus.lights)) begin
        err_s     = 1'b1;
        valid_s   = 1'b0;
        cnt_s     = 4'd0;
        prev_ok_s = 1'b0;
      end else if (!prev_ok_r) begin
        prev_s    = bus.lights;
        prev_ok_s = 1'b1;
      end else begin
        prev_s = bus.lights;
        if (cls_s == CLS_ILL) begin
          err_s   = 1'b1;
          valid_s = 1'b0;
          cnt_s   = 4'd0;
        end else if (cls_s == cand_r) begin
          cnt_s = cnt_inc_s;
          if ((cnt_inc_s == LOCK_C) && !valid_r) begin
            lock_s = 1'b1;
          end else begin
            lock_s = 1'b0;
          end
        end else begin
          // A class change with a single-transition lock relocks immediately.
          cand_s      = cls_s;
          cnt_s       = 4'd1;
          valid_s     = 1'b0;
          lock_mode_s = cls_s;
          if (LOCK_C == 4'd1) begin
            lock_s = 1'b1;
          end else begin
            lock_s = 1'b0;
          end
        end
      end
    end else begin
      err_s = 1'b0;
    end

    if (lock_s) begin
      valid_s       = 1'b1;
      w_s           = lock_mode_s;
      locked_once_s = 1'b1;
      if (locked_once_r && (lock_mode_s != w_r) && (sw_r != 8'hFF)) begin
        sw_s = sw_r + 8'd1;
      end else begin
        sw_s = sw_r;
      end
    end else begin
      sw_s = sw_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r        <= 3'b000;
      prev_ok_r     <= 1'b0;
      cand_r        <= CLS_CALM;
      cnt_r         <= 4'd0;
      w_r           <= 2'b00;
      valid_r       <= 1'b0;
      err_r         <= 1'b0;
      sw_r          <= 8'd0;
      locked_once_r <= 1'b0;
    end else begin
      prev_r        <= prev_s;
      prev_ok_r     <= prev_ok_s;
      cand_r        <= cand_s;
      cnt_r         <= cnt_s;
      w_r           <= w_s;
      valid_r       <= valid_s;
      err_r         <= err_s;
      sw_r          <= sw_s;
      locked_once_r <= locked_once_s;
    end
  end

  assign bus.w          = w_r;
  assign bus.valid      = valid_r;
  assign bus.err        = err_r;
  assign bus.switch_cnt = sw_r;

endmodule

// File: tb/tb_wind_decoder.sv
// Directed vector table for the default lock depth, plus a hand-written
// single-transition-lock sequence that drives switch_cnt into saturation.
module tb_wind_decoder;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wind_decoder_if bus0 ();
  wind_decoder_if bus1 ();

  wind_decoder #(.LOCK_COUNT(3)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  wind_decoder #(.LOCK_COUNT(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] lights;
    logic [1:0] w;
    logic       valid;
    logic       err;
    logic [7:0] sw;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [2:0] l,
                     input logic [1:0] w, input logic v, input logic er, input logic [7:0] s);
    vec_t t;
    t.rst = r; t.en = e; t.lights = l; t.w = w; t.valid = v; t.err = er; t.sw = s;
    vecs.push_back(t);
  endtask

  task automatic chk1(input string name, input logic [1:0] w, input logic v,
                      input logic er, input logic [7:0] s);
    checks++;
    if ({bus1.w, bus1.valid, bus1.err, bus1.switch_cnt} !== {w, v, er, s}) begin
      errors++;
      $display("FAIL %s: got w=%b valid=%b err=%b sw=%0d, expected w=%b valid=%b err=%b sw=%0d",
               name, bus1.w, bus1.valid, bus1.err, bus1.switch_cnt, w, v, er, s);
    end
  endtask

  initial begin
    logic [2:0] seq [4];
    logic [1:0] cls [4];
    logic [1:0] last_w;
    logic [7:0] exp_sw;
    logic       first;

    rst0 = 1'b1; rst1 = 1'b1;
    bus0.en = 1'b0; bus0.lights = 3'b000;
    bus1.en = 1'b0; bus1.lights = 3'b000;

    //   rst   en    lights   w      valid err   sw
    add(1'b1, 1'b1, 3'b010, 2'b00, 1'b0, 1'b0, 8'd0);  // reset overrides en
    add(1'b0, 1'b1, 3'b010, 2'b00, 1'b0, 1'b0, 8'd0);  // prev load only
    add(1'b0, 1'b1, 3'b100, 2'b00, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b010, 2'b01, 1'b1, 1'b0, 8'd0);  // leftward lock, first lock
    add(1'b0, 1'b1, 3'b100, 2'b01, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b110, 2'b01, 1'b0, 1'b1, 8'd0);  // illegal code
    add(1'b0, 1'b1, 3'b001, 2'b01, 1'b0, 1'b0, 8'd0);  // reload prev only
    add(1'b0, 1'b1, 3'b010, 2'b01, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b100, 2'b01, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b001, 2'b01, 1'b1, 1'b0, 8'd0);  // relock, same mode
    add(1'b0, 1'b1, 3'b010, 2'b01, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b100, 2'b01, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b100, 2'b01, 1'b0, 1'b1, 8'd0);  // hold is illegal
    add(1'b0, 1'b1, 3'b001, 2'b01, 1'b0, 1'b0, 8'd0);  // count restarts at 1
    add(1'b0, 1'b1, 3'b010, 2'b01, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b101, 2'b01, 1'b0, 1'b0, 8'd0);  // calm candidate
    add(1'b0, 1'b1, 3'b010, 2'b01, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b101, 2'b00, 1'b1, 1'b0, 8'd1);  // calm lock, switch
    add(1'b0, 1'b1, 3'b010, 2'b00, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 8'd1);  // rightward breaks lock
    add(1'b0, 1'b1, 3'b100, 2'b00, 1'b0, 1'b0, 8'd1);
    add(1'b0, 1'b1, 3'b010, 2'b10, 1'b1, 1'b0, 8'd2);  // rightward lock
    add(1'b0, 1'b0, 3'b101, 2'b10, 1'b1, 1'b0, 8'd2);  // en=0 freeze
    add(1'b0, 1'b0, 3'b110, 2'b10, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 3'b000, 2'b10, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 3'b100, 2'b10, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 3'b001, 2'b10, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b1, 3'b001, 2'b10, 1'b1, 1'b0, 8'd2);  // prev was frozen at 010
    add(1'b1, 1'b1, 3'b100, 2'b00, 1'b0, 1'b0, 8'd0);  // reset mid-lock
    add(1'b0, 1'b1, 3'b100, 2'b00, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b010, 2'b00, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b001, 2'b00, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 3'b100, 2'b10, 1'b1, 1'b0, 8'd0);  // first lock after reset

    for (int i = 0; i < vecs.size(); i++) begin
      rst0 = vecs[i].rst;
      bus0.en = vecs[i].en;
      bus0.lights = vecs[i].lights;
      @(posedge clk);
      #1;
      checks++;
      if ({bus0.w, bus0.valid, bus0.err, bus0.switch_cnt} !==
          {vecs[i].w, vecs[i].valid, vecs[i].err, vecs[i].sw}) begin
        errors++;
        $display("FAIL vec%0d: got w=%b valid=%b err=%b sw=%0d, expected w=%b valid=%b err=%b sw=%0d",
                 i, bus0.w, bus0.valid, bus0.err, bus0.switch_cnt,
                 vecs[i].w, vecs[i].valid, vecs[i].err, vecs[i].sw);
      end
    end
    rst0 = 1'b1;

    // Single-transition lock: calm, calm, leftward, rightward per period.
    rst1 = 1'b1; bus1.en = 1'b1; bus1.lights = 3'b111;
    @(posedge clk); #1;
    chk1("lc1_reset", 2'b00, 1'b0, 1'b0, 8'd0);
    rst1 = 1'b0; bus1.lights = 3'b010;
    @(posedge clk); #1;
    chk1("lc1_prev", 2'b00, 1'b0, 1'b0, 8'd0);

    seq[0] = 3'b101; cls[0] = 2'b00;
    seq[1] = 3'b010; cls[1] = 2'b00;
    seq[2] = 3'b100; cls[2] = 2'b01;
    seq[3] = 3'b010; cls[3] = 2'b10;
    first  = 1'b1;
    exp_sw = 8'd0;
    last_w = 2'b00;
    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < 4; j++) begin
        bus1.lights = seq[j];
        @(posedge clk); #1;
        if (!first && (cls[j] != last_w) && (exp_sw != 8'd255)) exp_sw = exp_sw + 8'd1;
        first  = 1'b0;
        last_w = cls[j];
        chk1("lc1_step", cls[j], 1'b1, 1'b0, exp_sw);
      end
    end
    checks++;
    if (bus1.switch_cnt !== 8'd255) begin
      errors++;
      $display("FAIL lc1_saturate: got sw=%0d, expected sw=255", bus1.switch_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
